keypad_scan_decoder: RTL and testbench

Parametrised matrix-keypad front end for the lock datapath. It drives keypad rows one-hot, samples the columns through a synchroniser, and debounces whole scan frames. It outputs a stable one-hot key vector, a binary key code, press/release strobes and a multi-key flag. It replaces static row/column-to-key decoding and feeds the code-entry logic directly.

---
 rtl/keypad_scan_decoder.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_decoder.sv
// Matrix keypad front end: one-hot row scan, synchronised column sampling,
// whole-frame debounce, and stable key / strobe outputs for the code-entry logic.
module keypad_scan_decoder #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 4,
  localparam int NKEY    = ROWS * COLS,
  localparam int CW      = $clog2(NKEY)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_drv,
  output logic [NKEY-1:0] key_onehot,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_press,
  output logic            key_release,
  output logic            multi_key
);

  localparam int RW  = $clog2(ROWS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DCW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EVAL} state_t;
  typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} kind_t;

  // A frame or stable state: its class plus the key index (zero unless SINGLE),
  // so two classes can be compared as plain packed values.
  typedef struct packed {
    kind_t         kind;
    logic [CW-1:0] idx;
  } cls_t;

  localparam cls_t NO_KEY = '{kind: C_NONE, idx: '0};

  state_t          state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [DW-1:0]   div, div_n;
  logic [COLS-1:0] col_s1, col_s2;
  logic [NKEY-1:0] bitmap, bitmap_n;
  cls_t            cand, cand_n;
  logic [DCW-1:0]  dcnt, dcnt_n;
  cls_t            stable, stable_n;
  logic [CW-1:0]   code_q, code_n;
  logic            press_q, press_n;
  logic            release_q, release_n;

  cls_t            frame_cls;
  logic [1:0]      nbits;
  logic [CW-1:0]   hit;

  // Frame classification: population count saturating at two, index of the set bit.
  always_comb begin
    frame_cls = NO_KEY;
    nbits     = '0;
    hit       = '0;
    for (int i = 0; i < NKEY; i++) begin
      if (bitmap[i]) begin
        if (nbits != 2'd2) nbits = nbits + 2'd1;
        hit = CW'(i);
      end
    end
    if (nbits == 2'd1)      frame_cls = '{kind: C_SINGLE, idx: hit};
    else if (nbits == 2'd2) frame_cls = '{kind: C_MULTI, idx: '0};
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n   = state;
    row_n     = row;
    div_n     = div;
    bitmap_n  = bitmap;
    cand_n    = cand;
    dcnt_n    = dcnt;
    stable_n  = stable;
    code_n    = code_q;
    press_n   = 1'b0;
    release_n = 1'b0;
    row_drv   = '0;

    case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_SCAN;
          row_n   = '0;
          div_n   = '0;
        end
      end

      S_SCAN: begin
        row_drv[row] = 1'b1;
        if (div == DW'(SCAN_DIV - 1)) begin
          div_n = '0;
          for (int r = 0; r < ROWS; r++) begin
            if (row == RW'(r)) bitmap_n[r*COLS +: COLS] = bitmap[r*COLS +: COLS] | col_s2;
          end
          if (row == RW'(ROWS - 1)) state_n = S_EVAL;
          else                      row_n   = row + 1'b1;
        end else begin
          div_n = div + 1'b1;
        end
      end

      S_EVAL: begin
        if (frame_cls == cand) begin
          if (dcnt != DCW'(DEBOUNCE)) dcnt_n = dcnt + 1'b1;
        end else begin
          cand_n = frame_cls;
          dcnt_n = DCW'(1);
        end
        // Acceptance uses the counter as updated by this very frame.
        if (dcnt_n == DCW'(DEBOUNCE) && cand_n != stable) begin
          stable_n = cand_n;
          if (cand_n.kind == C_SINGLE) begin
            press_n = 1'b1;
            code_n  = cand_n.idx;
          end
          if (stable.kind == C_SINGLE) release_n = 1'b1;
        end
        bitmap_n = '0;
        state_n  = S_SCAN;
        row_n    = '0;
        div_n    = '0;
      end

      default: state_n = S_IDLE;
    endcase

    // Dropping enable abandons the frame and forgets everything but the last code.
    if (!en) begin
      state_n   = S_IDLE;
      row_n     = '0;
      div_n     = '0;
      bitmap_n  = '0;
      cand_n    = NO_KEY;
      dcnt_n    = '0;
      stable_n  = NO_KEY;
      press_n   = 1'b0;
      release_n = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop sees pre-edge values;
  // the frame bitmap is a handful of flops and is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      div       <= '0;
      col_s1    <= '0;
      col_s2    <= '0;
      bitmap    <= '0;
      cand      <= NO_KEY;
      dcnt      <= '0;
      stable    <= NO_KEY;
      code_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state     <= state_n;
      row       <= row_n;
      div       <= div_n;
      col_s1    <= col_in;
      col_s2    <= col_s1;
      bitmap    <= bitmap_n;
      cand      <= cand_n;
      dcnt      <= dcnt_n;
      stable    <= stable_n;
      code_q    <= code_n;
      press_q   <= press_n;
      release_q <= release_n;
    end
  end

  always_comb begin
    key_onehot = '0;
    if (stable.kind == C_SINGLE) key_onehot[stable.idx] = 1'b1;
  end

  assign key_valid   = (stable.kind == C_SINGLE);
  assign multi_key   = (stable.kind == C_MULTI);
  assign key_code    = code_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Randomised bench for keypad_scan_decoder: a simulated key matrix driven from
// row_drv, and a frame-level reference model built from cycle arithmetic.
module tb_keypad_scan_decoder;

  localparam int ROWS     = 4;
  localparam int COLS     = 3;
  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 3;
  localparam int NKEY     = ROWS * COLS;
  localparam int CW       = $clog2(NKEY);
  localparam int FRAME    = ROWS * SCAN_DIV + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [COLS-1:0] col_in;
  logic [ROWS-1:0] row_drv;
  logic [NKEY-1:0] key_onehot;
  logic [CW-1:0]   key_code;
  logic            key_valid, key_press, key_release, multi_key;

  logic [NKEY-1:0] keys;

  int checks = 0;
  int errors = 0;

  // Reference model: run flag, offset inside the frame, frame key set,
  // key history, and classes as ints (-1 none, -2 multi, k single key k).
  bit              m_run;
  int              m_off;
  logic [NKEY-1:0] fb, h0, h1, h2;
  int              m_cand, m_cnt, m_stable, m_code;
  bit              m_press, m_release;

  keypad_scan_decoder #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .col_in(col_in), .row_drv(row_drv),
    .key_onehot(key_onehot), .key_code(key_code), .key_valid(key_valid),
    .key_press(key_press), .key_release(key_release), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key connects its row line to its column line.
  always_comb begin
    col_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_drv[r] && keys[r*COLS + c]) col_in[c] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_off = 0; fb = '0; h0 = '0; h1 = '0; h2 = '0;
    m_cand = -1; m_cnt = 0; m_stable = -1; m_code = 0; m_press = 0; m_release = 0;
  endtask

  task automatic model_eval();
    int n, cls;
    n = $countones(fb);
    cls = (n == 0) ? -1 : -2;
    if (n == 1) for (int i = 0; i < NKEY; i++) if (fb[i]) cls = i;
    if (cls == m_cand) begin
      if (m_cnt < DEBOUNCE) m_cnt++;
    end else begin
      m_cand = cls;
      m_cnt  = 1;
    end
    if (m_cnt == DEBOUNCE && m_cand != m_stable) begin
      m_press   = (m_cand >= 0);
      m_release = (m_stable >= 0);
      if (m_cand >= 0) m_code = m_cand;
      m_stable = m_cand;
    end
    fb = '0;
  endtask

  // One clock edge of the model, using the inputs as they stood at that edge.
  task automatic model_step();
    int r;
    h2 = h1; h1 = h0; h0 = keys;
    m_press = 0; m_release = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_off = 0; fb = '0; end
    end else if (!en) begin
      m_run = 0; fb = '0; m_cand = -1; m_cnt = 0; m_stable = -1;
    end else if (m_off == FRAME - 1) begin
      model_eval();
      m_off = 0;
    end else begin
      // A row is captured on its last cycle; the synchroniser shows keys from two cycles back.
      if (m_off % SCAN_DIV == SCAN_DIV - 1) begin
        r = m_off / SCAN_DIV;
        for (int c = 0; c < COLS; c++) fb[r*COLS + c] = fb[r*COLS + c] | h2[r*COLS + c];
      end
      m_off++;
    end
  endtask

  function automatic logic [31:0] exp_row();
    logic [ROWS-1:0] v;
    v = '0;
    if (m_run && m_off < FRAME - 1) v[m_off / SCAN_DIV] = 1'b1;
    return 32'(v);
  endfunction

  function automatic logic [31:0] exp_outs();
    logic [NKEY-1:0] oh;
    oh = '0;
    if (m_stable >= 0) oh[m_stable] = 1'b1;
    return {12'b0, oh, CW'(m_code), (m_stable >= 0), m_press, m_release, (m_stable == -2)};
  endfunction

  function automatic logic [31:0] act_outs();
    return {12'b0, key_onehot, key_code, key_valid, key_press, key_release, multi_key};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("row_drv", 32'(row_drv), exp_row());
    check("outs", act_outs(), exp_outs());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, hold;
    rst_n = 1'b0; en = 1'b0; keys = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outs", act_outs(), 32'h0);
    check("reset_row", 32'(row_drv), 32'h0);
    rst_n = 1'b1; en = 1'b1;

    // Idle scanning, then key 5 (index 4) pressed and released.
    run(3 * FRAME);
    keys = 12'h010; run(6 * FRAME);
    keys = '0;      run(5 * FRAME);

    // Contact bounce on key 5, then a clean hold.
    for (int i = 0; i < 150; i++) begin
      if (i % 20 == 0) keys = keys ^ 12'h010;
      tick();
    end
    keys = 12'h010; run(5 * FRAME);
    keys = '0;      run(4 * FRAME);

    // Key 1 straight to key 9: simultaneous press and release.
    keys = 12'h001; run(5 * FRAME);
    keys = 12'h100; run(5 * FRAME);
    keys = '0;      run(4 * FRAME);

    // Keys 2 and 3 together, then key 3 alone.
    keys = 12'h006; run(5 * FRAME);
    keys = 12'h004; run(5 * FRAME);
    keys = '0;      run(4 * FRAME);

    // Enable dropped during row 2 with key 5 stable, then re-enabled.
    keys = 12'h010; run(5 * FRAME);
    for (int i = 0; i < 2 * FRAME && !(m_run && m_off == 2 * SCAN_DIV + 3); i++) tick();
    en = 1'b0; run(10);
    en = 1'b1; run(5 * FRAME);

    // Asynchronous reset mid-frame with a key stable: outputs clear without a clock edge.
    run(13);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", act_outs(), 32'h0);
    check("async_rst_row", 32'(row_drv), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(5 * FRAME);
    keys = '0; run(4 * FRAME);

    // Random key sets, hold times and occasional enable drops.
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, NKEY - 1);
      b = (a + $urandom_range(1, NKEY - 1)) % NKEY;
      case ($urandom_range(0, 3))
        0:       keys = '0;
        2:       begin keys = '0; keys[a] = 1'b1; keys[b] = 1'b1; end
        default: begin keys = '0; keys[a] = 1'b1; end
      endcase
      hold = $urandom_range(10, 150);
      run(hold);
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0; run($urandom_range(1, 40));
        en = 1'b1;
      end
    end
    keys = '0; run(4 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
